// File: rtl/adc128s052_pkg.sv
// adc128s052_pkg: shared widths and result type for the ADC128S052 driver and its consumers
package adc128s052_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int ADC_W  = 12;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [ADC_W-1:0] data;
    } adc_res_t;

    // The ADC returns data for the channel addressed lat frames earlier
    function automatic logic [CH_W-1:0] phys_ch(input logic [CH_W-1:0] ch, input int lat);
        return ch - CH_W'(lat);
    endfunction

endpackage

// File: rtl/adc128s052_ch_avg_if.sv
// adc128s052_ch_avg_if: driver-side sample stream and result valid/ready stream
interface adc128s052_ch_avg_if;
    import adc128s052_pkg::*;

    logic             s_valid;
    logic [CH_W-1:0]  s_channel;
    logic [15:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [CH_W-1:0]  m_channel;
    logic [ADC_W-1:0] m_data;

    modport master (
        output s_valid, s_channel, s_data, m_ready,
        input  m_valid, m_channel, m_data
    );

    modport slave (
        input  s_valid, s_channel, s_data, m_ready,
        output m_valid, m_channel, m_data
    );

endinterface

// File: rtl/adc128s052_ch_avg_fifo.sv
// adc_res_fifo: synchronous first-word-fall-through FIFO of adc_res_t, DEPTH a power of 2 (>=2)
module adc_res_fifo
    import adc128s052_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  adc_res_t din,
    output logic     full,
    input  logic     pop,
    output adc_res_t dout,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    adc_res_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            wr_en;
    logic            rd_en;

    // A pop frees the slot for a simultaneous push even when full
    assign wr_en = push & (!full | pop);
    assign rd_en = pop & !empty;
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc128s052_ch_avg.sv
// adc128s052_ch_avg: per-channel averaging of ADC128S052 frames into a valid/ready result FIFO.
// Define ADC_AVG_SNAPSHOT_EN to add the rd_ch/rd_data latest-result register bank.
module adc128s052_ch_avg
    import adc128s052_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int CH_LAT     = 1,
    parameter int SKIP       = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr_ovf,
    adc128s052_ch_avg_if.slave   bus,
    output logic                 overflow
`ifdef ADC_AVG_SNAPSHOT_EN
    ,
    input  logic [CH_W-1:0]      rd_ch,
    output logic [ADC_W-1:0]     rd_data
`endif
);

    localparam int AW = ADC_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int SW = $clog2(SKIP + 2);

    logic             v_d;
    logic [SW-1:0]    skip_cnt;
    logic [AW-1:0]    acc [NUM_CH];
    logic [CW-1:0]    cnt [NUM_CH];
    logic [CH_W-1:0]  ch;
    logic [ADC_W-1:0] sample;
    logic [AW-1:0]    sum;
    logic             priming;
    logic             take;
    logic             last;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    adc_res_t         res;
    adc_res_t         head;
    logic             unused_hi;

    assign ch        = phys_ch(bus.s_channel, CH_LAT);
    assign sample    = bus.s_data[ADC_W-1:0];
    assign unused_hi = ^bus.s_data[15:ADC_W];
    assign priming   = skip_cnt < SW'(SKIP);
    assign take      = v_d & en & !priming;
    assign sum       = acc[ch] + AW'(sample);
    assign last      = (AVG_LOG2 == 0) || (cnt[ch] == CW'((1 << AVG_LOG2) - 1));
    assign push      = take & last;
    assign res       = '{ch: ch, data: ADC_W'(sum >> AVG_LOG2)};
    assign pop       = bus.m_valid & bus.m_ready;
    assign drop      = push & full & !pop;

    // Data and channel lag s_valid by one cycle, so they are sampled while v_d is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_d      <= 1'b0;
            skip_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            v_d <= bus.s_valid & en;
            if (!en) begin
                skip_cnt <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (v_d && priming) begin
                skip_cnt <= skip_cnt + 1'b1;
            end else if (take) begin
                acc[ch] <= last ? '0 : sum;
                cnt[ch] <= last ? '0 : cnt[ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    adc_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (res),
        .full  (full),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

    assign bus.m_valid   = !empty;
    assign bus.m_channel = head.ch;
    assign bus.m_data    = head.data;

`ifdef ADC_AVG_SNAPSHOT_EN
    logic [ADC_W-1:0] bank [NUM_CH];

    // Updated on every completed average, even when the FIFO drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else if (push) begin
            bank[ch] <= res.data;
        end
    end

    assign rd_data = bank[rd_ch];
`endif

endmodule

// File: tb/tb_adc128s052_ch_avg.sv
// tb_adc128s052_ch_avg: randomized and directed checks of adc128s052_ch_avg against a queue-based model
module tb_adc128s052_ch_avg;
    import adc128s052_pkg::*;

    localparam int AVG_LOG2 = 2;
    localparam int CH_LAT   = 1;
    localparam int SKIP     = 1;
    localparam int DEPTH    = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clr_ovf;
    logic overflow;
    logic rand_ready;
`ifdef ADC_AVG_SNAPSHOT_EN
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
`endif

    adc128s052_ch_avg_if bus ();

    adc128s052_ch_avg #(
        .AVG_LOG2   (AVG_LOG2),
        .CH_LAT     (CH_LAT),
        .SKIP       (SKIP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_ovf  (clr_ovf),
        .bus      (bus),
        .overflow (overflow)
`ifdef ADC_AVG_SNAPSHOT_EN
        ,
        .rd_ch    (rd_ch),
        .rd_data  (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_res  = 0;

    int          sum_m [8];
    int          n_m [8];
    int          skip_m;
    bit          ovf_m;
    logic [11:0] bank_m [8];
    logic [14:0] q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        foreach (sum_m[i]) begin
            sum_m[i] = 0;
            n_m[i]   = 0;
        end
        skip_m = 0;
    endfunction

    // Behavioural reference: average N samples per physical channel with integer division
    function automatic void model_accept(input logic [2:0] raw, input logic [15:0] d);
        int p;
        logic [11:0] r;
        if (!en) return;
        if (skip_m < SKIP) begin
            skip_m++;
            return;
        end
        p = (int'(raw) - CH_LAT + 8) % 8;
        sum_m[p] += int'(d[11:0]);
        n_m[p]++;
        if (n_m[p] == (1 << AVG_LOG2)) begin
            r = 12'(sum_m[p] / (1 << AVG_LOG2));
            bank_m[p] = r;
            if (q.size() < DEPTH) q.push_back({3'(p), r});
            else ovf_m = 1'b1;
            sum_m[p] = 0;
            n_m[p]   = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] d, input int gap);
        tick();
        bus.s_valid   = 1'b1;
        bus.s_channel = 3'($urandom);
        bus.s_data    = 16'($urandom);
        tick();
        bus.s_valid   = 1'b0;
        bus.s_channel = ch;
        bus.s_data    = d;
        model_accept(ch, d);
        repeat (gap) tick();
    endtask

    task automatic wait_empty();
        int k = 0;
        while ((q.size() != 0 || bus.m_valid) && k < 400) begin
            tick();
            k++;
        end
        @(negedge clk);
        if (k >= 400) check("drain_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (q.size() == 0) check("res_unexpected", q.size(), 1);
            else check("res", {bus.m_channel, bus.m_data}, q.pop_front());
            n_res++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ds [4] = '{16'd1, 16'd2, 16'd3, 16'd5};
        int base;
        rst_n = 1'b0; en = 1'b0; clr_ovf = 1'b0; rand_ready = 1'b0;
        bus.s_valid = 1'b0; bus.s_channel = '0; bus.s_data = '0; bus.m_ready = 1'b1;
`ifdef ADC_AVG_SNAPSHOT_EN
        rd_ch = '0;
`endif
        model_clear();
        ovf_m = 1'b0;
        foreach (bank_m[i]) bank_m[i] = '0;
        repeat (3) tick();
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_channel", bus.m_channel, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        send(3'd1, 16'h0100, 3);
        repeat (3) send(3'd1, 16'h0100, 3);
        send(3'd1, 16'h0100, 0);
        @(negedge clk);
        check("lat_t1_valid", bus.m_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", bus.m_valid, 1);
        check("lat_t2_channel", bus.m_channel, 0);
        check("lat_t2_data", bus.m_data, 12'h100);

        foreach (ds[i]) send(3'd4, ds[i], 2);
        repeat (4) send(3'd4, 16'hF123, 2);
        repeat (4) send(3'd0, 16'h0FFF, 2);
        wait_empty();
        check("ovf_idle", overflow, 0);

        bus.m_ready = 1'b0;
        for (int r = 0; r < 9; r++)
            for (int k = 0; k < 4; k++) send(3'(r + 1), 16'($urandom), 1);
        repeat (3) tick();
        @(negedge clk);
        check("full_overflow", overflow, ovf_m);
        check("full_valid", bus.m_valid, 1);
        check("full_head", {bus.m_channel, bus.m_data}, q[0]);
        repeat (3) tick();
        check("hold_head", {bus.m_channel, bus.m_data}, q[0]);
        bus.m_ready = 1'b1;
        wait_empty();
        check("ovf_retained", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        ovf_m = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, ovf_m);

        send(3'd3, 16'h0123, 2);
        send(3'd3, 16'h0456, 2);
        tick();
        en = 1'b0;
        model_clear();
        tick();
        en = 1'b1;
        repeat (5) send(3'd3, 16'h0040, 2);
        wait_empty();
`ifdef ADC_AVG_SNAPSHOT_EN
        rd_ch = 3'd2;
        #1;
        check("snap_ch2", rd_data, 12'h040);
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send(3'($urandom), 16'($urandom), $urandom_range(1, 5));
            if ($urandom_range(0, 19) == 0) begin
                tick();
                en = 1'b0;
                model_clear();
                tick();
                en = 1'b1;
            end
        end
        rand_ready = 1'b0;
        bus.m_ready = 1'b1;
        wait_empty();
        check("rand_overflow", overflow, ovf_m);
`ifdef ADC_AVG_SNAPSHOT_EN
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            check("snap_bank", rd_data, bank_m[i]);
        end
`endif

        send(3'd2, 16'h0001, 2);
        send(3'd2, 16'h0002, 2);
        bus.m_ready = 1'b0;
        send(3'd2, 16'h0003, 0);
        send(3'd2, 16'h0004, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.m_valid, 0);
        check("mid_rst_channel", bus.m_channel, 0);
        check("mid_rst_data", bus.m_data, 0);
        check("mid_rst_overflow", overflow, 0);
        q.delete();
        model_clear();
        ovf_m = 1'b0;
        foreach (bank_m[i]) bank_m[i] = '0;
`ifdef ADC_AVG_SNAPSHOT_EN
        check("mid_rst_snap", rd_data, 0);
`endif
        tick();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        base = n_res;
        repeat (4) send(3'd5, 16'h0ABC, 2);
        repeat (4) tick();
        check("post_rst_no_res", bus.m_valid, 0);
        send(3'd5, 16'h0ABC, 2);
        wait_empty();
        check("post_rst_results", n_res - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
